// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scanner.
package seg7_pkg;

    // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] HEX_SEG_TABLE [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Bit position of the decimal point on the segment bus.
    localparam int SEG_DP = 7;

    // Converts an active-high pattern to the pin polarity of the board.
    function automatic logic [7:0] apply_pol(input logic [7:0] value, input logic act_low);
        return act_low ? ~value : value;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational 4-bit hex to active-high {g..a} segment decoder.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Table lookup; the full 0..F range is covered.
    always_comb begin
        seg = HEX_SEG_TABLE[hex];
    end

endmodule

// File: rtl/seg7_scan_ndigit.sv
// N-digit multiplexed seven-segment scanner with PWM brightness, guard
// phase, leading-zero blanking, tear-free frame latching and pin polarity.
//
// Timing hierarchy: prescaler tick -> PWM phase -> digit slot -> frame.
// Phase 0 of every slot is dark so segment changes never land on a lit anode.
module seg7_scan_ndigit
    import seg7_pkg::*;
#(
    parameter int CLK_FREQ    = 125_000_000,
    parameter int SCAN_HZ     = 8_000,
    parameter int NUM_DIGITS  = 4,
    parameter int BRIGHT_W    = 3,
    parameter int SEG_ACT_LOW = 1,
    parameter int DIG_ACT_LOW = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [4*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic                    BLANK_LZ,
    input  logic [BRIGHT_W-1:0]     BRIGHT,
    input  logic                    EN,
    output logic [7:0]              SEG,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    FRAME
);

    localparam int DIV_RAW = CLK_FREQ / SCAN_HZ;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

    localparam logic [7:0]            SEG_IDLE = apply_pol(8'h00, SEG_ACT_LOW != 0);
    localparam logic [7:0]            AN_IDLE8 = apply_pol(8'h00, DIG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = AN_IDLE8[NUM_DIGITS-1:0];

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BRIGHT_W-1:0]     phase_q, phase_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] digits_sh_q, digits_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic                    blz_sh_q, blz_sh_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    tick;
    logic                    phase_wrap;
    logic                    frame_load;
    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic [6:0]              dec_seg;

    // Prescaler, PWM phase and digit index chain.
    always_comb begin
        tick       = (cnt_q == CNT_MAX);
        phase_wrap = tick && (phase_q == '1);
        cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
        phase_d    = tick ? phase_q + BRIGHT_W'(1) : phase_q;
        idx_d      = idx_q;
        if (phase_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Shadow registers load only at the very start of a frame, so a frame
    // always shows one coherent snapshot of the inputs.
    always_comb begin
        frame_load  = !RST && (cnt_q == '0) && (phase_q == '0) && (idx_q == '0);
        digits_sh_d = frame_load ? DIGITS   : digits_sh_q;
        dp_sh_d     = frame_load ? DP       : dp_sh_q;
        blz_sh_d    = frame_load ? BLANK_LZ : blz_sh_q;
    end

    // Leading-zero detection from the top digit downward; digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank_vec  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero   = upper_zero && (digits_sh_q[4*i +: 4] == 4'h0);
            blank_vec[i] = (i != 0) && blz_sh_q && upper_zero;
        end
    end

    // Select the shadow digit, decimal point and blank flag for the active slot.
    always_comb begin
        cur_digit = digits_sh_q[3:0];
        cur_dp    = dp_sh_q[0];
        cur_blank = blank_vec[0];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = digits_sh_q[4*i +: 4];
                cur_dp    = dp_sh_q[i];
                cur_blank = blank_vec[i];
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .hex (cur_digit),
        .seg (dec_seg)
    );

    // Next output pattern: anode lit only in phases 1..BRIGHT, polarity applied last.
    always_comb begin
        logic                  lit;
        logic [7:0]            seg_raw;
        logic [NUM_DIGITS-1:0] an_onehot;
        logic [7:0]            an_pol;
        lit     = EN && (phase_q != '0) && (phase_q <= BRIGHT);
        seg_raw = 8'h00;
        if (EN) begin
            seg_raw[6:0]    = cur_blank ? 7'h00 : dec_seg;
            seg_raw[SEG_DP] = cur_dp;
        end
        an_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_onehot[i] = lit && (idx_q == IDX_W'(i));
        end
        seg_d  = apply_pol(seg_raw, SEG_ACT_LOW != 0);
        an_pol = apply_pol(8'(an_onehot), DIG_ACT_LOW != 0);
        an_d   = an_pol[NUM_DIGITS-1:0];
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q       <= '0;
            phase_q     <= '0;
            idx_q       <= '0;
            digits_sh_q <= '0;
            dp_sh_q     <= '0;
            blz_sh_q    <= 1'b0;
            seg_q       <= SEG_IDLE;
            an_q        <= AN_IDLE;
        end else begin
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            digits_sh_q <= digits_sh_d;
            dp_sh_q     <= dp_sh_d;
            blz_sh_q    <= blz_sh_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
        end
    end

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign FRAME = frame_load;

endmodule

// File: tb/tb_seg7_scan_ndigit.sv
// Directed testbench for seg7_scan_ndigit: DIV=4, 4 phases, 16-clk slots, 64-clk frames.
// Cycle k counts negedges since reset release; outputs at k reflect state cycle k-1,
// where phase = ((k-1)/4)%4 and digit = ((k-1)/16)%4.
module tb_seg7_scan_ndigit;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        blank_lz;
  logic [1:0]  bright;
  logic        en;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame;

  int checks;
  int errors;
  int k;

  seg7_scan_ndigit #(
    .CLK_FREQ    (8),
    .SCAN_HZ     (2),
    .NUM_DIGITS  (4),
    .BRIGHT_W    (2),
    .SEG_ACT_LOW (1),
    .DIG_ACT_LOW (1)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .DIGITS   (digits),
    .DP       (dp),
    .BLANK_LZ (blank_lz),
    .BRIGHT   (bright),
    .EN       (en),
    .SEG      (seg),
    .AN       (an),
    .FRAME    (frame)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hand-computed active-low patterns, indexed by digit position 0..3
  logic [7:0] seg_1234 [4];
  logic [7:0] seg_5678 [4];
  logic [7:0] seg_blnk [4];

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  // reset pulse of n cycles; returns at the negedge of the first cycle after release (k=0)
  task automatic do_reset(input int n);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    k = 0;
    @(negedge clk);
  endtask

  function automatic logic [3:0] an_for(input int id);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << id);
  endfunction

  task automatic test_reset();
    digits = 16'h1234; dp = 4'h0; blank_lz = 1'b0; bright = 2'd3; en = 1'b1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected FF", seg); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h expected F", an); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame); end
    @(posedge clk);
    #1 rst = 1'b0;
    k = 0;
    @(negedge clk);
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL release_frame: got %b expected 1", frame); end
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL release_an: got %h expected F", an); end
    step();
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL frame_pulse_len: got %b expected 0", frame); end
    while (k < 4) step();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL guard_phase_an: got %h expected F", an); end
    step();
    checks++; if (an !== 4'hE) begin errors++; $display("FAIL first_lit_an: got %h expected E", an); end
  endtask

  task automatic test_scan();
    int lit_cnt [4];
    int ph, id;
    logic [3:0] exp_an;
    digits = 16'h1234; dp = 4'h0; blank_lz = 1'b0; bright = 2'd3; en = 1'b1;
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    do_reset(2);
    while (k < 64) begin
      step();
      ph = ((k - 1) / 4) % 4;
      id = ((k - 1) / 16) % 4;
      exp_an = (ph >= 1) ? an_for(id) : 4'hF;
      checks++;
      if (an !== exp_an) begin errors++; $display("FAIL scan_an k=%0d: got %h expected %h", k, an, exp_an); end
      if (ph >= 1) begin
        checks++;
        if (seg !== seg_1234[id]) begin errors++; $display("FAIL scan_seg k=%0d: got %h expected %h", k, seg, seg_1234[id]); end
      end
      for (int d = 0; d < 4; d++) if (an === an_for(d)) lit_cnt[d]++;
    end
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL second_frame: got %b expected 1", frame); end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (lit_cnt[d] != 12) begin errors++; $display("FAIL scan_lit_cnt d=%0d: got %0d expected 12", d, lit_cnt[d]); end
    end
  endtask

  task automatic test_blanking();
    int ph, id;
    digits = 16'h0050; dp = 4'b0100; blank_lz = 1'b1; bright = 2'd3; en = 1'b1;
    do_reset(2);
    while (k < 64) begin
      step();
      ph = ((k - 1) / 4) % 4;
      id = ((k - 1) / 16) % 4;
      if (ph == 2) begin
        checks++;
        if (seg !== seg_blnk[id]) begin errors++; $display("FAIL blank_seg d=%0d: got %h expected %h", id, seg, seg_blnk[id]); end
      end
    end
  endtask

  task automatic test_brightness();
    int lit_cnt [4];
    int dark_bad;
    digits = 16'h1234; dp = 4'h0; blank_lz = 1'b0; bright = 2'd0; en = 1'b1;
    dark_bad = 0;
    do_reset(2);
    while (k < 64) begin
      step();
      if (an !== 4'hF) dark_bad++;
    end
    checks++; if (dark_bad != 0) begin errors++; $display("FAIL bright0_dark: got %0d lit cycles expected 0", dark_bad); end
    bright = 2'd1;
    for (int d = 0; d < 4; d++) lit_cnt[d] = 0;
    do_reset(2);
    while (k < 64) begin
      step();
      for (int d = 0; d < 4; d++) if (an === an_for(d)) lit_cnt[d]++;
      if (((k - 1) / 4) % 4 != 1) begin
        checks++;
        if (an !== 4'hF) begin errors++; $display("FAIL bright1_phase k=%0d: got %h expected F", k, an); end
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (lit_cnt[d] != 4) begin errors++; $display("FAIL bright1_cnt d=%0d: got %0d expected 4", d, lit_cnt[d]); end
    end
  endtask

  task automatic test_tear_free();
    int ph, id;
    logic [7:0] exp_seg;
    digits = 16'h1234; dp = 4'h0; blank_lz = 1'b0; bright = 2'd3; en = 1'b1;
    do_reset(2);
    while (k < 128) begin
      step();
      if (k == 24) digits = 16'h5678;
      if (k == 64) begin
        checks++;
        if (frame !== 1'b1) begin errors++; $display("FAIL tear_frame: got %b expected 1", frame); end
      end
      ph = ((k - 1) / 4) % 4;
      id = ((k - 1) / 16) % 4;
      exp_seg = (k <= 64) ? seg_1234[id] : seg_5678[id];
      if (ph == 3) begin
        checks++;
        if (seg !== exp_seg) begin errors++; $display("FAIL tear_seg k=%0d: got %h expected %h", k, seg, exp_seg); end
      end
    end
  endtask

  task automatic test_enable_reset();
    digits = 16'h1234; dp = 4'h0; blank_lz = 1'b0; bright = 2'd3; en = 1'b1;
    do_reset(2);
    while (k < 21) step();
    checks++; if (an !== 4'hD) begin errors++; $display("FAIL en_pre_an: got %h expected D", an); end
    en = 1'b0;
    step();
    checks++; if (an !== 4'hF) begin errors++; $display("FAIL en_off_an: got %h expected F", an); end
    checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL en_off_seg: got %h expected FF", seg); end
    while (k < 30) step();
    checks++; if (an !== 4'hF || seg !== 8'hFF) begin errors++; $display("FAIL en_off_hold: got an=%h seg=%h expected F FF", an, seg); end
    en = 1'b1;
    step();
    checks++; if (an !== 4'hD) begin errors++; $display("FAIL en_resume_an: got %h expected D", an); end
    checks++; if (seg !== seg_1234[1]) begin errors++; $display("FAIL en_resume_seg: got %h expected %h", seg, seg_1234[1]); end
    while (k < 38) step();
    checks++; if (an !== 4'hB) begin errors++; $display("FAIL pre_rst_an: got %h expected B", an); end
    do_reset(1);
    checks++; if (an !== 4'hF || seg !== 8'hFF) begin errors++; $display("FAIL midrst_idle: got an=%h seg=%h expected F FF", an, seg); end
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL midrst_frame: got %b expected 1", frame); end
    while (k < 5) step();
    checks++; if (an !== 4'hE) begin errors++; $display("FAIL midrst_restart_an: got %h expected E", an); end
    checks++; if (seg !== seg_1234[0]) begin errors++; $display("FAIL midrst_restart_seg: got %h expected %h", seg, seg_1234[0]); end
  endtask

  initial begin
    checks = 0; errors = 0; k = 0;
    rst = 1'b1; en = 1'b1; digits = '0; dp = '0; blank_lz = 1'b0; bright = '0;
    seg_1234 = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    seg_5678 = '{8'h80, 8'hF8, 8'h82, 8'h92};
    seg_blnk = '{8'hC0, 8'h92, 8'h7F, 8'hFF};
    test_reset();
    test_scan();
    test_blanking();
    test_brightness();
    test_tear_free();
    test_enable_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
